usb_rx_data_buffer: RTL and testbench

//  Packet-aware byte FIFO directly downstream of the USB receiver; drives its fifo_full/fifo_empty/read_done inputs.
//  - Receiver writes decoded bytes with fill_dbuff, then commits the packet (CRC good) or aborts it (CRC bad).
//  - The SD-side reader only ever sees committed bytes.

---
 rtl/usb_rx_data_buffer.sv | 121 ++++++++++++
 tb/tb_usb_rx_data_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_data_buffer.sv
// Packet-aware receive byte FIFO: speculative writes, commit/abort, 1-cycle pop.
// Optional per-packet statistics: define USB_RXBUF_STATS_EN.
module usb_rx_data_buffer #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_dbuff,
   input  logic [7:0]        rx_data,
   input  logic              pkt_commit,
   input  logic              pkt_abort,
   input  logic              dbuff_clr,
   input  logic              rd_en,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              fifo_empty,
   output logic              fifo_full,
   output logic              read_done,
   output logic [ADDR_W:0]   count,
   output logic              overflow
`ifdef USB_RXBUF_STATS_EN
   ,
   output logic [7:0]        pkt_cnt,
   output logic [7:0]        drop_cnt
`endif
);

   localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

   logic [7:0]      mem [DEPTH];
   logic [ADDR_W:0] wr_ptr, cmt_ptr, rd_ptr;
   logic [ADDR_W:0] wr_nxt, cmt_nxt, rd_inc, wr_inc;
   logic            bad_pkt;
   logic            wr_ok, wr_drop, rd_ok;
   logic            bad_cmt, good_cmt;

   assign fifo_full  = (wr_ptr - rd_ptr) == DEPTH_P;
   assign fifo_empty = cmt_ptr == rd_ptr;
   assign count      = cmt_ptr - rd_ptr;

   assign wr_ok   = fill_dbuff & ~fifo_full;
   assign wr_drop = fill_dbuff & fifo_full;
   assign rd_ok   = rd_en & ~fifo_empty & ~dbuff_clr;
   assign rd_inc  = rd_ptr + 1'b1;
   assign wr_inc  = wr_ptr + {{ADDR_W{1'b0}}, wr_ok};

   // A byte dropped in the commit cycle itself still spoils the packet
   assign bad_cmt  = pkt_commit & ~pkt_abort & (bad_pkt | wr_drop);
   assign good_cmt = pkt_commit & ~pkt_abort & ~bad_cmt;

   always_comb begin
      wr_nxt  = wr_ptr;
      cmt_nxt = cmt_ptr;
      if (pkt_abort | bad_cmt) begin
         wr_nxt = cmt_ptr;
      end else if (good_cmt) begin
         wr_nxt  = wr_inc;
         cmt_nxt = wr_inc;
      end else begin
         wr_nxt = wr_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok & ~rst & ~dbuff_clr)
         mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         cmt_ptr   <= '0;
         rd_ptr    <= '0;
         bad_pkt   <= 1'b0;
         overflow  <= 1'b0;
         rd_valid  <= 1'b0;
         read_done <= 1'b0;
         rd_data   <= 8'h00;
      end else if (dbuff_clr) begin
         wr_ptr    <= '0;
         cmt_ptr   <= '0;
         rd_ptr    <= '0;
         bad_pkt   <= 1'b0;
         overflow  <= 1'b0;
         rd_valid  <= 1'b0;
         read_done <= 1'b0;
      end else begin
         wr_ptr  <= wr_nxt;
         cmt_ptr <= cmt_nxt;
         if (wr_drop)
            overflow <= 1'b1;
         if (pkt_abort | pkt_commit)
            bad_pkt <= 1'b0;
         else if (wr_drop)
            bad_pkt <= 1'b1;
         rd_valid  <= rd_ok;
         // compare against the post-commit pointer so new bytes cancel it
         read_done <= rd_ok & (rd_inc == cmt_nxt);
         if (rd_ok) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr  <= rd_inc;
         end
      end
   end

`ifdef USB_RXBUF_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt  <= 8'h00;
         drop_cnt <= 8'h00;
      end else if (!dbuff_clr) begin
         if (good_cmt && pkt_cnt != 8'hFF)
            pkt_cnt <= pkt_cnt + 8'h01;
         if ((pkt_abort | bad_cmt) && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'h01;
      end
   end
`endif

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Scoreboard bench for usb_rx_data_buffer: queue-based packet model,
// directed cases then randomized phases.
module tb_usb_rx_data_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fill_dbuff = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       pkt_commit = 1'b0;
   logic       pkt_abort = 1'b0;
   logic       dbuff_clr = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, fifo_empty, fifo_full, read_done, overflow;
   logic [6:0] count;
`ifdef USB_RXBUF_STATS_EN
   logic [7:0] pkt_cnt, drop_cnt;
`endif

   usb_rx_data_buffer #(.DEPTH(64), .ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .fill_dbuff(fill_dbuff), .rx_data(rx_data),
      .pkt_commit(pkt_commit), .pkt_abort(pkt_abort),
      .dbuff_clr(dbuff_clr), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .read_done(read_done), .count(count),
      .overflow(overflow)
`ifdef USB_RXBUF_STATS_EN
      , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         done;
      int         due;
   } exp_t;

   exp_t       exq[$];
   logic [7:0] comm[$];
   logic [7:0] pend[$];
   bit         m_ovf, m_bad;
   int         m_pkt, m_drop;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exq.size() > 0 && exq[0].due < cyc) begin
         chk("rd_valid_missing", int'(rd_valid), 1);
         void'(exq.pop_front());
      end
      if (rd_valid === 1'b1) begin
         if (exq.size() == 0) begin
            chk("rd_valid_unexpected", int'(rd_valid), 0);
         end else begin
            e = exq.pop_front();
            chk("rd_data", int'(rd_data), int'(e.d));
            chk("read_done", int'(read_done), int'(e.done));
            chk("rd_latency", cyc, e.due);
         end
      end else if (read_done === 1'b1) begin
         chk("read_done_stray", int'(read_done), 0);
      end
   end

   task automatic check_status();
      chk("count", int'(count), comm.size());
      chk("fifo_empty", int'(fifo_empty), int'(comm.size() == 0));
      chk("fifo_full", int'(fifo_full),
          int'(comm.size() + pend.size() == 64));
      chk("overflow", int'(overflow), int'(m_ovf));
`ifdef USB_RXBUF_STATS_EN
      chk("pkt_cnt", int'(pkt_cnt), m_pkt);
      chk("drop_cnt", int'(drop_cnt), m_drop);
`endif
   endtask

   task automatic step(input bit f, input logic [7:0] d,
                       input bit c, input bit a,
                       input bit clr, input bit r);
      bit   full, popped, drop;
      exp_t e;
      @(negedge clk);
      #1;
      check_status();
      fill_dbuff = f;
      rx_data    = d;
      pkt_commit = c;
      pkt_abort  = a;
      dbuff_clr  = clr;
      rd_en      = r;
      if (clr) begin
         comm.delete();
         pend.delete();
         m_ovf = 0;
         m_bad = 0;
      end else begin
         full   = (comm.size() + pend.size()) == 64;
         drop   = f && full;
         popped = 0;
         if (r && comm.size() > 0) begin
            e.d    = comm.pop_front();
            popped = 1;
         end
         if (drop) m_ovf = 1;
         if (a) begin
            pend.delete();
            m_bad = 0;
            if (m_drop < 255) m_drop++;
         end else if (c) begin
            if (m_bad || drop) begin
               if (m_drop < 255) m_drop++;
            end else begin
               if (f) pend.push_back(d);
               foreach (pend[i]) comm.push_back(pend[i]);
               if (m_pkt < 255) m_pkt++;
            end
            pend.delete();
            m_bad = 0;
         end else begin
            if (f && !full) pend.push_back(d);
            if (drop) m_bad = 1;
         end
         if (popped) begin
            e.done = comm.size() == 0;
            e.due  = cyc + 1;
            exq.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic wr(input logic [7:0] d);
      step(1, d, 0, 0, 0, 0);
   endtask

   task automatic pop(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1;
      {fill_dbuff, pkt_commit, pkt_abort, dbuff_clr, rd_en} = '0;
      comm.delete();
      pend.delete();
      exq.delete();
      m_ovf  = 0;
      m_bad  = 0;
      m_pkt  = 0;
      m_drop = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 0;
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_read_done", int'(read_done), 0);
      check_status();
   endtask

   initial begin
      int pw, pr, pc, pa;
      do_reset();

      wr(8'h11); wr(8'h22); wr(8'h33);
      step(0, 8'h00, 1, 0, 0, 0);
      pop(3);
      idle(2);

      for (int i = 0; i < 5; i++) wr(8'(8'h50 + i));
      step(0, 8'h00, 0, 1, 0, 0);
      idle(1);
      wr(8'hA5);
      step(0, 8'h00, 1, 0, 0, 0);
      pop(1);
      idle(2);

      step(0, 8'h00, 0, 0, 1, 0);
      for (int i = 0; i < 64; i++) wr(8'(i * 3 + 1));
      idle(1);
      wr(8'hEE);
      idle(1);
      step(0, 8'h00, 1, 0, 0, 0);
      idle(2);

      wr(8'h77);
      step(0, 8'h00, 1, 0, 0, 0);
      wr(8'h88); wr(8'h99);
      step(0, 8'h00, 1, 0, 0, 1);
      idle(1);
      pop(2);
      idle(2);

      wr(8'h01); wr(8'h02);
      step(0, 8'h00, 1, 0, 0, 0);
      wr(8'h03);
      step(0, 8'h00, 0, 0, 1, 1);
      idle(2);
      pop(1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 40; i++) wr(8'($urandom));
         step(0, 8'h00, 1, 0, 0, 0);
         pop(40);
         idle(1);
      end

      for (int ph = 0; ph < 10; ph++) begin
         pw = $urandom_range(30, 95);
         pr = (ph % 3 == 0) ? $urandom_range(0, 10) : $urandom_range(20, 90);
         pc = $urandom_range(2, 15);
         pa = $urandom_range(0, 4);
         for (int i = 0; i < 200; i++)
            step($urandom_range(0, 99) < pw, 8'($urandom),
                 $urandom_range(0, 99) < pc, $urandom_range(0, 99) < pa,
                 $urandom_range(0, 499) == 0, $urandom_range(0, 99) < pr);
      end

      wr(8'h5A); wr(8'h5B);
      do_reset();
      idle(2);
      pop(1);
      idle(3);
      chk("scoreboard_drained", exq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
